// File: rtl/coax_rx_buffer_pkg.sv
// Shared definitions for the coax receive buffer: receiver error codes and FSM states.
package coax_rx_buffer_pkg;

  localparam int WORD_W = 10;

  // Error codes shared with the coax receiver; one bit per fault class.
  localparam logic [WORD_W-1:0] ERROR_LOSS_OF_MID_BIT_TRANSITION = 10'd1;
  localparam logic [WORD_W-1:0] ERROR_PARITY                     = 10'd2;
  localparam logic [WORD_W-1:0] ERROR_INVALID_END_SEQUENCE       = 10'd4;
  localparam logic [WORD_W-1:0] ERROR_OVERFLOW                   = 10'd8;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVING,
    ERROR
  } rx_state_e;

endpackage

// File: rtl/coax_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush and occupancy count.
module coax_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty FIFO is dropped; a push on a full FIFO only succeeds with a same-cycle pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign count = wr_cnt - rd_cnt;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rd_cnt[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (flush) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so both counters update from the same pre-edge values.
      if (do_push) wr_cnt <= wr_cnt + 1'b1;
      if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the counters alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_cnt[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/coax_rx_buffer.sv
// Receive buffer behind the coax receiver: frames words into a FWFT FIFO,
// latches receiver/overflow errors and pulses frame_end when the line goes idle.
module coax_rx_buffer
  import coax_rx_buffer_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_active,
  input  logic                     rx_error,
  input  logic [9:0]               rx_data,
  input  logic                     rx_strobe,
  input  logic                     read_strobe,
  input  logic                     clear,
  output logic [9:0]               data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     error,
  output logic                     frame_end
);

  rx_state_e         state, next_state;
  logic [WORD_W-1:0] err_code, next_code;
  logic [WORD_W-1:0] head;
  logic              next_frame_end;
  logic              push, pop, push_req, overflow;

  coax_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (depth)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      err_code  <= '0;
      frame_end <= 1'b0;
    end else begin
      state     <= next_state;
      err_code  <= next_code;
      frame_end <= next_frame_end;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state     = state;
    next_code      = err_code;
    next_frame_end = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    push_req       = 1'b0;
    overflow       = 1'b0;

    if (clear) begin
      next_state = IDLE;
    end else if (state != ERROR) begin
      // While rx_error is high rx_data carries a code, not a word.
      push_req = rx_strobe && !rx_error;
      push     = push_req;
      pop      = read_strobe;
      overflow = push_req && full && !(read_strobe && !empty);

      if (rx_error) begin
        next_state = ERROR;
        next_code  = rx_data;
      end else if (overflow) begin
        next_state = ERROR;
        next_code  = ERROR_OVERFLOW;
      end else if (state == IDLE && rx_active) begin
        next_state = RECEIVING;
      end else if (state == RECEIVING && !rx_active) begin
        next_state     = IDLE;
        next_frame_end = 1'b1;
      end
    end
  end

  assign error = (state == ERROR);
  assign data  = error ? err_code : (empty ? '0 : head);

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Self-checking bench for coax_rx_buffer: vector table, scoreboard queue and corner-case sequences.
module tb_coax_rx_buffer;
  import coax_rx_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_active, rx_error, rx_strobe, read_strobe, clear;
  logic [9:0]    rx_data;
  logic [9:0]    data;
  logic          empty, full, error, frame_end;
  logic [DW-1:0] depth;

  int errors = 0;
  int checks = 0;
  logic [9:0] sb [$];
  bit sb_on;

  typedef struct {
    logic act, err;
    logic [9:0] rdat;
    logic stb, rd, clr;
    logic [9:0] e_data;
    logic e_empty, e_full;
    logic [DW-1:0] e_depth;
    logic e_error, e_fe;
  } vec_t;

  vec_t tbl [10];

  coax_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_active   (rx_active),
    .rx_error    (rx_error),
    .rx_data     (rx_data),
    .rx_strobe   (rx_strobe),
    .read_strobe (read_strobe),
    .clear       (clear),
    .data        (data),
    .empty       (empty),
    .full        (full),
    .depth       (depth),
    .error       (error),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle; the scoreboard compares the head at each accepted pop and records accepted pushes.
  task automatic cyc(input logic act, input logic err, input logic [9:0] d,
                     input logic stb, input logic rd, input logic clr);
    rx_active   = act;
    rx_error    = err;
    rx_data     = d;
    rx_strobe   = stb;
    read_strobe = rd;
    clear       = clr;
    if (sb_on && !clr) begin
      if (rd && sb.size() > 0) check("sb_pop", {6'd0, data}, {6'd0, sb.pop_front()});
      if (stb && !err && sb.size() < DEPTH) sb.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string name, input logic [9:0] e_data, input logic e_empty,
                             input logic e_full, input logic [DW-1:0] e_depth, input logic e_error,
                             input logic e_fe);
    check({name, "_data"}, {6'd0, data}, {6'd0, e_data});
    check({name, "_flags"}, {9'd0, empty, full, depth, error, frame_end},
          {9'd0, e_empty, e_full, e_depth, e_error, e_fe});
  endtask

  initial begin
    // Basic frame: three words, line drops, three pops, then a pop on empty.
    tbl[0] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 10'h001, 1'b1, 1'b0, 1'b0, 10'h001, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 10'h2AA, 1'b1, 1'b0, 1'b0, 10'h001, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0, 1'b0, 10'h001, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h001, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h001, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h2AA, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

    reset = 1'b1;
    rx_active = 1'b0; rx_error = 1'b0; rx_data = '0;
    rx_strobe = 1'b0; read_strobe = 1'b0; clear = 1'b0;
    sb_on = 1'b1;
    @(posedge clk); #1;
    check_flags("reset", 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].act, tbl[i].err, tbl[i].rdat, tbl[i].stb, tbl[i].rd, tbl[i].clr);
      check_flags($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_empty, tbl[i].e_full,
                  tbl[i].e_depth, tbl[i].e_error, tbl[i].e_fe);
    end

    // Overflow: fill to full, push without pop, pop ignored in ERROR, clear recovers.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 10'h0A0 + 10'(i), 1'b1, 1'b0, 1'b0);
    check_flags("fill", 10'h0A0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 10'h155, 1'b1, 1'b0, 1'b0);
    check_flags("ovf", 10'h008, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
    sb_on = 1'b0;
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    check_flags("ovf_pop", 10'h008, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    check_flags("ovf_clr", 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    sb.delete();
    sb_on = 1'b1;

    // Full with concurrent push and pop: no overflow, new word drains last.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 10'h101 + 10'(i), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 10'h105, 1'b1, 1'b1, 1'b0);
    check_flags("full_pp", 10'h102, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    check_flags("full_drain", 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);

    // Receiver error mid-frame after two words.
    cyc(1'b1, 1'b0, 10'h011, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 10'h012, 1'b1, 1'b0, 1'b0);
    sb_on = 1'b0;
    cyc(1'b1, 1'b1, 10'h002, 1'b0, 1'b0, 1'b0);
    check_flags("rxerr", 10'h002, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    check_flags("rxerr_pop", 10'h002, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    check_flags("rxerr_clr", 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 10'h0AB, 1'b1, 1'b0, 1'b0);
    check_flags("idle_push", 10'h0AB, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    // Clear wins over a held rx_error, which then re-enters ERROR on the next cycle.
    cyc(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 1'b1);
    check_flags("clr_hold", 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 1'b0);
    check_flags("reenter", 10'h004, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    check("reenter_clr", {15'd0, error}, 16'd0);
    sb.delete();
    sb_on = 1'b1;

    // Streaming: push and pop every cycle, occupancy stays at one.
    cyc(1'b1, 1'b0, 10'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 10'($urandom), 1'b1, 1'b1, 1'b0);
      check($sformatf("stream%0d_depth", i), {13'd0, depth}, 16'd1);
    end
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    check("stream_empty", {15'd0, empty}, 16'd1);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame with a full FIFO.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 10'h3C0 + 10'(i), 1'b1, 1'b0, 1'b0);
    check("pre_reset_depth", {13'd0, depth}, 16'd4);
    #3;
    reset = 1'b1;
    #1;
    check_flags("async_reset", 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    sb.delete();
    rx_active = 1'b0; rx_strobe = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_flags("post_reset", 10'h000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
